// File: rtl/rts_step_ctrl_if.sv
// Handshake bundle between the step controller and the solver/host side.
// Latency: none (wires only).
// Backpressure: none; all signals are single-cycle pulses or levels.
//
// Signals:
//   init_pulse, en, done[N_SOLVER], clr_ovr   : towards the controller
//   start, step_end, step_busy, step_cnt,
//   overrun, overrun_cnt                      : from the controller
interface rts_step_ctrl_if #(
  parameter int N_SOLVER = 5,
  parameter int CNT_W    = 32
);
  logic                init_pulse;
  logic                en;
  logic [N_SOLVER-1:0] done;
  logic                clr_ovr;
  logic                start;
  logic                step_end;
  logic                step_busy;
  logic [CNT_W-1:0]    step_cnt;
  logic                overrun;
  logic [15:0]         overrun_cnt;

  modport master (
    output init_pulse, en, done, clr_ovr,
    input  start, step_end, step_busy, step_cnt, overrun, overrun_cnt
  );

  modport slave (
    input  init_pulse, en, done, clr_ovr,
    output start, step_end, step_busy, step_cnt, overrun, overrun_cnt
  );
endinterface

// File: rtl/rts_step_ctrl.sv
// Real-time step pacer: issues start every STEP_CYCLES clocks, collects solver done pulses, flags deadline misses.
// Latency: en in ARMED -> start next cycle; last done -> step_end/step_cnt next cycle; overrun the cycle after the tick.
// Backpressure: none; late steps keep running and missed slots are skipped, never queued.
//
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : rts_step_ctrl_if.slave (init_pulse, en, done, clr_ovr in;
//               start, step_end, step_busy, step_cnt, overrun, overrun_cnt out)
module rts_step_ctrl #(
  parameter int N_SOLVER    = 5,
  parameter int STEP_CYCLES = 500,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  rts_step_ctrl_if.slave   bus
);

  localparam int TMR_W = $clog2(STEP_CYCLES);
  localparam logic [TMR_W-1:0] LAST = TMR_W'(STEP_CYCLES - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_COMPUTE = 2'd2;
  localparam logic [1:0] S_WAIT    = 2'd3;

  logic [1:0]          r_state;
  logic [TMR_W-1:0]    r_timer;
  logic [N_SOLVER-1:0] r_done_lat;
  logic                r_start;
  logic                r_step_end;
  logic                r_busy;
  logic [CNT_W-1:0]    r_step_cnt;
  logic                r_overrun;
  logic [15:0]         r_overrun_cnt;

  logic [1:0]          w_nxt_state;
  logic [TMR_W-1:0]    w_nxt_timer;
  logic [N_SOLVER-1:0] w_nxt_lat;
  logic [N_SOLVER-1:0] w_lat;
  logic                w_all;
  logic                w_tick;
  logic                w_start;
  logic                w_end;
  logic                w_miss;

  always_comb begin
    w_lat       = r_done_lat | bus.done;
    w_all       = &w_lat;
    w_tick      = (r_timer == LAST);
    w_nxt_state = r_state;
    w_nxt_timer = '0;
    w_nxt_lat   = r_done_lat;
    w_start     = 1'b0;
    w_end       = 1'b0;
    w_miss      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.init_pulse) w_nxt_state = S_ARMED;
      end
      S_ARMED: begin
        if (bus.en) begin
          w_nxt_state = S_COMPUTE;
          w_start     = 1'b1;
          w_nxt_lat   = '0;
        end
      end
      S_COMPUTE: begin
        w_nxt_timer = w_tick ? '0 : r_timer + TMR_W'(1);
        w_nxt_lat   = w_lat;
        if (w_all) begin
          w_end = 1'b1;
          if (!w_tick) begin
            w_nxt_state = S_WAIT;
          end else if (bus.en) begin
            // Finished exactly on the slot boundary: roll straight into the next step.
            w_start   = 1'b1;
            w_nxt_lat = '0;
          end else begin
            w_nxt_state = S_ARMED;
          end
        end else if (w_tick) begin
          // Deadline missed: keep collecting, no new start for this slot.
          w_miss = 1'b1;
        end
      end
      S_WAIT: begin
        w_nxt_timer = w_tick ? '0 : r_timer + TMR_W'(1);
        if (w_tick) begin
          if (bus.en) begin
            w_nxt_state = S_COMPUTE;
            w_start     = 1'b1;
            w_nxt_lat   = '0;
          end else begin
            w_nxt_state = S_ARMED;
          end
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_timer       <= '0;
      r_done_lat    <= '0;
      r_start       <= 1'b0;
      r_step_end    <= 1'b0;
      r_busy        <= 1'b0;
      r_step_cnt    <= '0;
      r_overrun     <= 1'b0;
      r_overrun_cnt <= '0;
    end else begin
      r_state    <= w_nxt_state;
      r_timer    <= w_nxt_timer;
      r_done_lat <= w_nxt_lat;
      r_start    <= w_start;
      r_step_end <= w_end;
      r_busy     <= (w_nxt_state == S_COMPUTE);
      if (w_end) r_step_cnt <= r_step_cnt + CNT_W'(1);
      // A new miss wins over a coincident clear: the count restarts at 1.
      if (w_miss) begin
        r_overrun <= 1'b1;
        if (bus.clr_ovr)                  r_overrun_cnt <= 16'd1;
        else if (r_overrun_cnt != 16'hFFFF) r_overrun_cnt <= r_overrun_cnt + 16'd1;
      end else if (bus.clr_ovr) begin
        r_overrun     <= 1'b0;
        r_overrun_cnt <= '0;
      end
    end
  end

  assign bus.start       = r_start;
  assign bus.step_end    = r_step_end;
  assign bus.step_busy   = r_busy;
  assign bus.step_cnt    = r_step_cnt;
  assign bus.overrun     = r_overrun;
  assign bus.overrun_cnt = r_overrun_cnt;

endmodule

// File: tb/tb_rts_step_ctrl.sv
module tb_rts_step_ctrl;
  localparam int NS = 5;
  localparam int SC = 8;
  localparam int CW = 32;
  localparam logic [NS-1:0] ALL = '1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rts_step_ctrl_if #(.N_SOLVER(NS), .CNT_W(CW)) u_if ();

  rts_step_ctrl #(.N_SOLVER(NS), .STEP_CYCLES(SC), .CNT_W(CW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: slot position, whether a step is open, which solvers reported.
  int          m_mode;   // 0 waiting for init, 1 waiting for en, 2 running slots
  bit          m_open;
  int          m_pos;
  bit [NS-1:0] m_got;
  logic [CW-1:0] m_steps;
  bit          m_ovr;
  int          m_ovc;
  bit          e_start, e_end;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  task model_reset();
    m_mode = 0; m_open = 0; m_pos = 0; m_got = '0; m_steps = '0;
    m_ovr = 0; m_ovc = 0; e_start = 0; e_end = 0;
  endtask

  task model_step(input bit init, input bit en, input bit [NS-1:0] done, input bit clr);
    bit tick, miss;
    e_start = 0; e_end = 0; miss = 0;
    if (m_mode == 0) begin
      if (init) m_mode = 1;
    end else if (m_mode == 1) begin
      if (en) begin m_mode = 2; m_open = 1; m_got = '0; m_pos = 0; e_start = 1; end
    end else begin
      tick = (m_pos == SC - 1);
      if (m_open) begin
        m_got = m_got | done;
        if (m_got == ALL) begin e_end = 1; m_steps = m_steps + 1; m_open = 0; end
        else if (tick) miss = 1;
      end
      m_pos = tick ? 0 : m_pos + 1;
      if (tick && !m_open) begin
        if (en) begin m_open = 1; m_got = '0; e_start = 1; end
        else m_mode = 1;
      end
    end
    if (miss) begin
      m_ovr = 1;
      m_ovc = clr ? 1 : (m_ovc < 65535 ? m_ovc + 1 : m_ovc);
    end else if (clr) begin
      m_ovr = 0; m_ovc = 0;
    end
  endtask

  task chk_model();
    chk("start",       {31'd0, u_if.start},       {31'd0, e_start});
    chk("step_end",    {31'd0, u_if.step_end},    {31'd0, e_end});
    chk("step_busy",   {31'd0, u_if.step_busy},   {31'd0, (m_mode == 2 && m_open)});
    chk("step_cnt",    u_if.step_cnt,             m_steps);
    chk("overrun",     {31'd0, u_if.overrun},     {31'd0, m_ovr});
    chk("overrun_cnt", {16'd0, u_if.overrun_cnt}, m_ovc);
  endtask

  // Drive one cycle of inputs, advance one edge, compare against the model.
  task cyc(input bit init, input bit en, input bit [NS-1:0] done, input bit clr);
    u_if.init_pulse = init; u_if.en = en; u_if.done = done; u_if.clr_ovr = clr;
    @(posedge clk);
    model_step(init, en, done, clr);
    #1;
    chk_model();
  endtask

  // Asserts reset mid-cycle and checks outputs clear without waiting for an edge.
  task do_reset();
    u_if.init_pulse = 0; u_if.en = 0; u_if.done = '0; u_if.clr_ovr = 0;
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("rst_start", {31'd0, u_if.start}, 0);
    chk("rst_end",   {31'd0, u_if.step_end}, 0);
    chk("rst_busy",  {31'd0, u_if.step_busy}, 0);
    chk("rst_cnt",   u_if.step_cnt, 0);
    chk("rst_ovr",   {31'd0, u_if.overrun}, 0);
    chk("rst_ovc",   {16'd0, u_if.overrun_cnt}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Reset, init with en high; returns inside the first start cycle.
  task arm();
    do_reset();
    cyc(1, 1, '0, 0);
    chk("arm_nostart_yet", {31'd0, u_if.start}, 0);
    cyc(0, 1, '0, 0);
    chk("arm_start_lat2", {31'd0, u_if.start}, 1);
  endtask

  typedef struct {
    bit          init, en;
    bit [NS-1:0] done;
    bit          st, se, busy;
    int          cnt;
  } vec_t;

  function automatic vec_t mk(bit init, bit en, bit [NS-1:0] done, bit st, bit se, bit busy, int cnt);
    vec_t v;
    v.init = init; v.en = en; v.done = done; v.st = st; v.se = se; v.busy = busy; v.cnt = cnt;
    return v;
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[23];
    int   n_end;
    bit [NS-1:0] d;

    // Steady stepping: init+en, all done 3 cycles after each start.
    tbl[0]  = mk(1, 1, '0,  0, 0, 0, 0);
    tbl[1]  = mk(0, 1, '0,  1, 0, 1, 0);
    tbl[2]  = mk(0, 1, '0,  0, 0, 1, 0);
    tbl[3]  = mk(0, 1, '0,  0, 0, 1, 0);
    tbl[4]  = mk(0, 1, '0,  0, 0, 1, 0);
    tbl[5]  = mk(0, 1, ALL, 0, 1, 0, 1);
    tbl[6]  = mk(0, 1, '0,  0, 0, 0, 1);
    tbl[7]  = mk(0, 1, '0,  0, 0, 0, 1);
    tbl[8]  = mk(0, 1, '0,  0, 0, 0, 1);
    tbl[9]  = mk(0, 1, '0,  1, 0, 1, 1);
    tbl[10] = mk(0, 1, '0,  0, 0, 1, 1);
    tbl[11] = mk(0, 1, '0,  0, 0, 1, 1);
    tbl[12] = mk(0, 1, '0,  0, 0, 1, 1);
    tbl[13] = mk(0, 1, ALL, 0, 1, 0, 2);
    tbl[14] = mk(0, 1, '0,  0, 0, 0, 2);
    tbl[15] = mk(0, 1, '0,  0, 0, 0, 2);
    tbl[16] = mk(0, 1, '0,  0, 0, 0, 2);
    tbl[17] = mk(0, 1, '0,  1, 0, 1, 2);
    tbl[18] = mk(0, 1, '0,  0, 0, 1, 2);
    tbl[19] = mk(0, 1, '0,  0, 0, 1, 2);
    tbl[20] = mk(0, 1, '0,  0, 0, 1, 2);
    tbl[21] = mk(0, 1, ALL, 0, 1, 0, 3);
    tbl[22] = mk(0, 1, '0,  0, 0, 0, 3);

    model_reset();
    u_if.init_pulse = 0; u_if.en = 0; u_if.done = '0; u_if.clr_ovr = 0;
    do_reset();
    for (int i = 0; i < 23; i++) begin
      cyc(tbl[i].init, tbl[i].en, tbl[i].done, 1'b0);
      chk($sformatf("tbl%0d_start", i), {31'd0, u_if.start},     {31'd0, tbl[i].st});
      chk($sformatf("tbl%0d_end", i),   {31'd0, u_if.step_end},  {31'd0, tbl[i].se});
      chk($sformatf("tbl%0d_busy", i),  {31'd0, u_if.step_busy}, {31'd0, tbl[i].busy});
      chk($sformatf("tbl%0d_cnt", i),   u_if.step_cnt,           tbl[i].cnt);
      chk($sformatf("tbl%0d_ovr", i),   {31'd0, u_if.overrun},   0);
    end

    // Staggered done with a repeated bit0: step_end once, at +6.
    arm();
    n_end = 0;
    for (int k = 0; k < 8; k++) begin
      d = (k == 1) ? 5'h01 : (k == 2) ? 5'h0E : (k == 3) ? 5'h01 : (k == 5) ? 5'h10 : 5'h00;
      cyc(0, 1, d, 0);
      if (u_if.step_end) n_end++;
      chk($sformatf("stag_end_p%0d", k + 1), {31'd0, u_if.step_end}, {31'd0, (k + 1 == 6)});
    end
    chk("stag_end_count", n_end, 1);

    // Done withheld until +10: overrun after first tick, restart at the tick after completion.
    arm();
    for (int k = 0; k < 17; k++) begin
      cyc(0, 1, (k == 10) ? ALL : '0, 0);
      if (k + 1 == 8) begin
        chk("late_ovr", {31'd0, u_if.overrun}, 1);
        chk("late_ovc", {16'd0, u_if.overrun_cnt}, 1);
      end
      if (k + 1 == 11) chk("late_end", {31'd0, u_if.step_end}, 1);
      chk($sformatf("late_start_p%0d", k + 1), {31'd0, u_if.start}, {31'd0, (k + 1 == 16)});
    end

    // Last done exactly on the tick: no overrun, step_end and start together.
    arm();
    for (int k = 0; k < 8; k++) cyc(0, 1, (k == 2) ? 5'h0F : (k == 7) ? 5'h10 : 5'h00, 0);
    chk("tick_done_end",   {31'd0, u_if.step_end}, 1);
    chk("tick_done_start", {31'd0, u_if.start}, 1);
    chk("tick_done_ovr",   {31'd0, u_if.overrun}, 0);

    // clr_ovr coincident with a second overrun, then en dropped mid-step.
    arm();
    for (int k = 0; k < 16; k++) cyc(0, 1, '0, k == 15);
    chk("clr_set_ovr", {31'd0, u_if.overrun}, 1);
    chk("clr_set_ovc", {16'd0, u_if.overrun_cnt}, 1);
    n_end = 0;
    for (int k = 16; k < 40; k++) begin
      cyc(0, 0, (k == 17) ? ALL : '0, 0);
      if (u_if.step_end) n_end++;
      chk($sformatf("endrop_nostart_p%0d", k + 1), {31'd0, u_if.start}, 0);
    end
    chk("endrop_completed", n_end, 1);
    chk("endrop_idle_busy", {31'd0, u_if.step_busy}, 0);
    cyc(0, 1, '0, 1);
    chk("armed_restart", {31'd0, u_if.start}, 1);
    chk("clr_only_ovr", {31'd0, u_if.overrun}, 0);

    // Reset mid-COMPUTE: inputs ignored until a fresh init_pulse.
    arm();
    cyc(0, 1, 5'h03, 0);
    cyc(0, 1, '0, 0);
    do_reset();
    for (int k = 0; k < 12; k++) begin
      cyc(0, 1, ALL, 0);
      chk("postrst_start", {31'd0, u_if.start}, 0);
      chk("postrst_cnt", u_if.step_cnt, 0);
    end
    cyc(1, 1, '0, 0);
    cyc(0, 1, '0, 0);
    chk("postrst_rearm", {31'd0, u_if.start}, 1);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      for (int b = 0; b < NS; b++) d[b] = ($urandom_range(0, 4) == 0);
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 9) != 0, d, $urandom_range(0, 49) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/rts_step_ctrl.md
# rts_step_ctrl

Real-time time-step controller for the FPGA simulator. It arms on the one-shot initialisation-complete pulse from the end-signal combiner and then paces the solver stages. It issues a periodic `start` pulse every `STEP_CYCLES` clocks and collects per-solver `done` pulses. It reports step completion and a step count, and flags any solver set that misses its real-time deadline.

## Interface
Parameters:
- `N_SOLVER`, default 5: number of solver done inputs.
- `STEP_CYCLES`, default 500: clocks per simulation time-step. Legal values are ≥ 4.
- `CNT_W`, default 32: width of `step_cnt`.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `init_pulse`, in, 1: one-cycle initialisation-complete pulse from the end-signal combiner.
- `en`, in, 1: run enable (level).
- `done`, in, `N_SOLVER`: per-solver one-cycle completion pulses.
- `clr_ovr`, in, 1: clears `overrun` and `overrun_cnt`.
- `start`, out, 1: one-cycle step-start pulse to all solvers.
- `step_end`, out, 1: one-cycle pulse when all solvers have finished the current step.
- `step_busy`, out, 1: high while in COMPUTE.
- `step_cnt`, out, `CNT_W`: completed-step count. Wraps modulo 2^`CNT_W`.
- `overrun`, out, 1: sticky deadline-miss flag.
- `overrun_cnt`, out, 16: deadline-miss count. Saturates at 16'hFFFF.

## Operation
- All outputs are registered. On reset, every output is 0, the state is IDLE, `timer` is 0 and `done_lat` is 0.
- States:
  - IDLE: `timer` is held at 0. `init_pulse` moves the FSM to ARMED. `init_pulse` is ignored in all other states.
  - ARMED: `timer` is held at 0. If `en`=1, then on the next cycle `start`=1, `done_lat` is cleared, `timer`=0 and the state is COMPUTE.
  - COMPUTE: `timer` increments by 1 every cycle and wraps to 0 after `STEP_CYCLES`-1; "tick" means `timer`==`STEP_CYCLES`-1. Each cycle, `done_lat` <= `done_lat` | `done`.
    - Completion: (`done_lat` | `done`) is all ones. On the next cycle, `step_end`=1, `step_cnt`+1 and the state is WAIT.
    - Tick without completion: `overrun`<=1 and `overrun_cnt` increments (saturating). The state stays COMPUTE and `timer` wraps. No new `start` is issued; the late step keeps collecting `done`.
    - Completion on the tick cycle: this is not an overrun. On the next cycle, `step_end` is pulsed. If `en`=1, `start` is pulsed in that same cycle with `done_lat` cleared, and the state stays COMPUTE. If `en`=0, the state goes to ARMED.
  - WAIT: `timer` keeps counting. On the tick, if `en`=1, the next cycle has `start`=1, `done_lat` cleared, `timer`=0 and state COMPUTE. If `en`=0, the state goes to ARMED.
- A late-completing step (after an overrun) goes to WAIT and restarts at the next tick, so missed slots are skipped, never queued.
- Deasserting `en` mid-step does not abort the step. It takes effect at the next step boundary.
- A `done` bit pulsed more than once in a step has no extra effect. A `done` bit sampled in the same cycle as `start` is discarded (the latch is cleared).
- `clr_ovr` zeroes `overrun` and `overrun_cnt`. If it coincides with a new overrun, the set wins: `overrun`=1 and `overrun_cnt`=1.
- Reset mid-operation returns the block to IDLE. A new `init_pulse` is required before running again.

## Timing
- `en`=1 sampled in ARMED at edge k gives `start`=1 in cycle k+1.
- Steady state: `start` pulses are exactly `STEP_CYCLES` clocks apart.
- Last missing `done` sampled at edge c gives `step_end`=1 and updated `step_cnt` in cycle c+1. `step_busy` falls in that same cycle.
- An overrun is flagged in the cycle after the tick.
- Latency from `init_pulse` to first `start` with `en` held high is 2 cycles.

## Test plan
- Reset, then `init_pulse` with `en`=1, `STEP_CYCLES`=8, all `done` pulsed 3 cycles after each `start`. Required: `start` every 8 clocks; `step_end` 1 cycle after the done pulses; `step_cnt` goes 1, 2, 3; `overrun`=0.
- Staggered `done` (bit0 at +1, bit4 at +5, others at +2) plus a repeated bit0. Required: `step_end` exactly once, at +6.
- `done` withheld until 10 cycles after `start`, with `STEP_CYCLES`=8. Required: `overrun`=1 and `overrun_cnt`=1 after the first tick; no second `start` until the tick following completion.
- Last `done` arriving exactly on the tick cycle. Required: no overrun; `step_end` and `start` asserted in the same cycle.
- `clr_ovr` pulsed coincident with an overrun. Required: `overrun`=1, `overrun_cnt`=1. `en` dropped mid-step: the step completes, then the FSM is in ARMED with no further `start`.
- Asynchronous `rst` asserted mid-COMPUTE. Required: all outputs 0 immediately; `done` pulses and `en` ignored until a new `init_pulse` arrives.
